// File: rtl/reg_file_rd_ctrlr.sv
// rtl/reg_file_rd_ctrlr.sv - decode-stage register read-port controller with RAW scoreboard and issue slice
// Optional feature macro: RF_WB_BYPASS_EN (same-cycle writeback resolves hazards)
module reg_file_rd_ctrlr #(
    parameter int ADDR_W  = 5,
    parameter int NREGS   = 32,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              alu_op,
    input  logic              imm_op,
    input  logic              mem_op,
    input  logic              write_op,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [ADDR_W-1:0] raddr1,
    output logic [ADDR_W-1:0] raddr2,
    output logic              ren1,
    output logic              ren2,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_wen,
    output logic [ADDR_W-1:0] out_waddr,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    output logic              stall
);

    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);

    logic [NREGS-1:0]  sb_q, sb_d;
    logic [CNT_W-1:0]  out_cnt_q, out_cnt_d;
    logic              out_valid_q, out_valid_d;
    logic              out_wen_q, out_wen_d;
    logic [ADDR_W-1:0] out_waddr_q, out_waddr_d;

    logic              wen;
    logic [ADDR_W-1:0] dest;
    logic              retire_hit;
    logic [NREGS-1:0]  sb_eff;
    logic              cnt_full;
    logic              haz;
    logic              accept;
    logic              issue_cnt;

    // Op-class decode: read enables, write enable and destination selection
    always_comb begin
        ren1 = alu_op | mem_op;
        ren2 = (alu_op & ~imm_op) | (mem_op & write_op);
        wen  = alu_op | (mem_op & ~write_op);
        dest = (mem_op | (alu_op & imm_op)) ? rt_addr : rd_addr;
    end

    assign raddr1 = rs_addr;
    assign raddr2 = rt_addr;

    // Hazard view of the scoreboard; a retire only counts when it hits a busy register
    always_comb begin
        retire_hit = wb_en && (wb_addr != '0) && sb_q[wb_addr];
        sb_eff     = sb_q;
        cnt_full   = (out_cnt_q == CNT_MAX);
`ifdef RF_WB_BYPASS_EN
        if (retire_hit) begin
            sb_eff[wb_addr] = 1'b0;
        end
        cnt_full = (out_cnt_q == CNT_MAX) && !retire_hit;
`endif
        haz = (ren1 && (rs_addr != '0) && sb_eff[rs_addr]) ||
              (ren2 && (rt_addr != '0) && sb_eff[rt_addr]) ||
              (wen && cnt_full);
    end

    assign in_ready  = (~out_valid_q | out_ready) & ~haz;
    assign stall     = in_valid & ~in_ready;
    assign accept    = in_valid & in_ready;
    assign issue_cnt = accept & wen & (dest != '0);

    // Next state: output slice, scoreboard (set beats clear) and saturating outstanding counter
    always_comb begin
        out_valid_d = out_valid_q;
        out_wen_d   = out_wen_q;
        out_waddr_d = out_waddr_q;
        sb_d        = sb_q;
        out_cnt_d   = out_cnt_q;

        if (accept) begin
            out_valid_d = 1'b1;
            out_wen_d   = wen;
            out_waddr_d = dest;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (retire_hit) begin
            sb_d[wb_addr] = 1'b0;
        end
        if (issue_cnt) begin
            sb_d[dest] = 1'b1;
        end

        if (issue_cnt && !retire_hit && (out_cnt_q != CNT_MAX)) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end else if (!issue_cnt && retire_hit && (out_cnt_q != '0)) begin
            out_cnt_d = out_cnt_q - CNT_W'(1);
        end
    end

    // State registers; an op in flight at reset is discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q        <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_wen_q   <= 1'b0;
            out_waddr_q <= '0;
        end else begin
            sb_q        <= sb_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
            out_wen_q   <= out_wen_d;
            out_waddr_q <= out_waddr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_wen   = out_wen_q;
    assign out_waddr = out_waddr_q;

endmodule
